programmable_clock_divider: RTL

Multi-channel, run-time-programmable successor to the fixed-divisor clock divider. It generates `CHANNELS` independent divided clock enables/waveforms from `clock_in`, each with its own divisor and high-time. New settings are accepted through a valid/ready write port and applied glitch-free at the channel's next period boundary. It sits between the board clock and the slow-rate consumers of the matrix-multiplication datapath: the LED/debug blink, the stepping clock and the sample strobes.

---
 rtl/programmable_clock_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/programmable_clock_divider.sv
// -----------------------------------------------------------------------------
// programmable_clock_divider
//
// Purpose:
//   Generates CHANNELS independent divided waveforms from clock_in. Each
//   channel has its own divisor and high-time. New settings arrive through a
//   valid/ready write port. They are held pending and applied only at the
//   channel's next period boundary, or at once while the channel is disabled,
//   so a running period is never truncated.
//
// Optional feature (macro CLKDIV_SYNC_EN):
//   Adds a sync input. A sync cycle forces every enabled channel to wrap,
//   which phase-aligns all channels and applies any pending updates.
//
// Ports:
//   clock_in     in   1          single clock for all logic
//   reset        in   1          asynchronous active-high reset
//   enable       in   CHANNELS   per-channel run enable
//   wr_valid     in   1          write request
//   wr_ready     out  1          write can be accepted (combinational on wr_chan)
//   wr_chan      in   CH_W       target channel
//   wr_div       in   CNT_W      new divisor
//   wr_high      in   CNT_W      new high-time in clock_in cycles
//   clock_out    out  CHANNELS   registered divided waveforms
//   period_start out  CHANNELS   one-cycle pulse per channel wrap
//   sync         in   1          phase-align strobe (CLKDIV_SYNC_EN only)
// -----------------------------------------------------------------------------
module programmable_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 8,
    parameter int CH_W        = $clog2(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [CNT_W-1:0]    wr_div,
    input  logic [CNT_W-1:0]    wr_high,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] period_start
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic                sync
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(DEFAULT_DIV / 2);

    // Active settings, counters and pending updates per channel
    logic [CNT_W-1:0]    r_cnt      [CHANNELS];
    logic [CNT_W-1:0]    r_div      [CHANNELS];
    logic [CNT_W-1:0]    r_hi       [CHANNELS];
    logic [CNT_W-1:0]    r_pend_div [CHANNELS];
    logic [CNT_W-1:0]    r_pend_hi  [CHANNELS];
    logic [CHANNELS-1:0] r_pend_v;
    logic [CHANNELS-1:0] r_clock_out;
    logic [CHANNELS-1:0] r_period_start;

    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_accept;
    logic                w_wr_ready;
    logic                w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    assign wr_ready     = w_wr_ready;
    assign clock_out    = r_clock_out;
    assign period_start = r_period_start;

    // Wrap detection per channel and write-port decode
    always_comb begin
        w_wrap     = '0;
        w_accept   = '0;
        w_wr_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            // Divisors 0 and 1 wrap every cycle; the explicit test also keeps
            // div-1 from underflowing to all-ones when div is 0.
            w_wrap[i] = enable[i] &&
                        (w_sync || (r_div[i] <= ONE) || (r_cnt[i] >= (r_div[i] - ONE)));
            if (wr_chan == CH_W'(i)) begin
                w_wr_ready  = !r_pend_v[i];
                w_accept[i] = wr_valid && !r_pend_v[i];
            end else begin
                w_accept[i] = 1'b0;
            end
        end
        // A channel index past CHANNELS matches no channel: ready stays high
        // and the write is silently dropped.
    end

    // Channel counters, registered waveforms and pending-update bookkeeping
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]      <= ZERO;
                r_div[i]      <= RST_DIV;
                r_hi[i]       <= RST_HI;
                r_pend_div[i] <= ZERO;
                r_pend_hi[i]  <= ZERO;
            end
            r_pend_v       <= '0;
            r_clock_out    <= '0;
            r_period_start <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!enable[i]) begin
                    r_cnt[i]          <= ZERO;
                    r_clock_out[i]    <= 1'b0;
                    r_period_start[i] <= 1'b0;
                end else begin
                    r_cnt[i]          <= w_wrap[i] ? ZERO : (r_cnt[i] + ONE);
                    // Uses the pre-update count and the settings still active
                    // this cycle, so the wrap cycle belongs to the old period.
                    r_clock_out[i]    <= (r_cnt[i] < r_hi[i]);
                    r_period_start[i] <= w_wrap[i];
                end

                // Apply only at a boundary (counter is already restarting).
                // Accept and apply are exclusive on one channel via pend_v.
                if (r_pend_v[i] && (w_wrap[i] || !enable[i])) begin
                    r_div[i]    <= r_pend_div[i];
                    r_hi[i]     <= r_pend_hi[i];
                    r_pend_v[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_pend_div[i] <= wr_div;
                    r_pend_hi[i]  <= wr_high;
                    r_pend_v[i]   <= 1'b1;
                end else begin
                    r_pend_v[i] <= r_pend_v[i];
                end
            end
        end
    end

endmodule
